// File: rtl/mano_seq_ctrl.sv
// Instruction-cycle sequencer for the Mano CPU.
// Owns the one-hot sequence counter (T states), the cycle phase decode, the
// interrupt flip-flops R and IEN, the halt state and a sticky wrap error.
// Handshake: a T state that issues a memory access raises mem_req and holds it
// until mem_ready; the sequencer holds every state-advance decision
// (including sc_clr) while mem_req & ~mem_ready.
module mano_seq_ctrl #(
    parameter int          NT     = 8,
    parameter logic [2:0]  OPC_IO = 3'b111
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    ir_opcode,
    input  logic          ir_i,
    input  logic          sc_clr,
    input  logic          hlt,
    input  logic          ien_set,
    input  logic          ien_clr,
    input  logic          fgi,
    input  logic          fgo,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic [NT-1:0] t_state,
    output logic [2:0]    phase,
    output logic          r_flag,
    output logic          ien,
    output logic          int_ack,
    output logic          halted,
    output logic          seq_err
);

    typedef enum logic [2:0] {
        PH_FETCH    = 3'd0,
        PH_DECODE   = 3'd1,
        PH_INDIRECT = 3'd2,
        PH_EXECUTE  = 3'd3,
        PH_INTR     = 3'd4
    } phase_e;

    localparam logic [NT-1:0] T0_ONEHOT = {{(NT-1){1'b0}}, 1'b1};

    logic [NT-1:0] sc_q, sc_d;
    logic          r_q, r_d;
    logic          ien_q, ien_d;
    logic          halted_q, halted_d;
    logic          seq_err_q, seq_err_d;
    logic          int_ack_q, int_ack_d;
    phase_e        phase_w;

    logic stall;
    logic early;      // T0..T2
    logic intr_done;  // non-stalled edge leaving T2 of the interrupt cycle

    assign stall     = mem_req & ~mem_ready;
    assign early     = |sc_q[2:0];
    assign intr_done = ~stall & ~halted_q & r_q & sc_q[2];

    // State registers; reset restores T0 and clears all flags immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_q      <= T0_ONEHOT;
            r_q       <= 1'b0;
            ien_q     <= 1'b0;
            halted_q  <= 1'b0;
            seq_err_q <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            sc_q      <= sc_d;
            r_q       <= r_d;
            ien_q     <= ien_d;
            halted_q  <= halted_d;
            seq_err_q <= seq_err_d;
            int_ack_q <= int_ack_d;
        end
    end

    // Next-state logic for the sequence counter, halt and wrap error.
    always_comb begin
        sc_d      = sc_q;
        halted_d  = halted_q;
        seq_err_d = seq_err_q;
        if (!stall) begin
            if (halted_q) begin
                sc_d = T0_ONEHOT;
            end else if (r_q && sc_q[2]) begin
                sc_d = T0_ONEHOT;
            end else if (sc_clr && !early) begin
                sc_d = T0_ONEHOT;
                if (hlt) begin
                    halted_d = 1'b1;
                end
            end else if (sc_q[NT-1]) begin
                sc_d      = T0_ONEHOT;
                seq_err_d = 1'b1;
            end else begin
                sc_d = {sc_q[NT-2:0], 1'b0};
            end
        end
    end

    // Interrupt flip-flops: R is only set outside T0..T2 so it is stable for
    // the whole fetch/interrupt window; it is sampled even on stalled edges.
    always_comb begin
        r_d       = r_q;
        ien_d     = ien_q;
        int_ack_d = intr_done;
        if (intr_done) begin
            r_d = 1'b0;
        end else if (!early && ien_q && (fgi || fgo)) begin
            r_d = 1'b1;
        end
        if (intr_done) begin
            ien_d = 1'b0;
        end else if (ien_clr) begin
            ien_d = 1'b0;
        end else if (ien_set) begin
            ien_d = 1'b1;
        end
    end

    // Phase decode from the current T state, R and the instruction register.
    always_comb begin
        phase_w = PH_EXECUTE;
        if (early && r_q) begin
            phase_w = PH_INTR;
        end else if (sc_q[0] || sc_q[1]) begin
            phase_w = PH_FETCH;
        end else if (sc_q[2]) begin
            phase_w = PH_DECODE;
        end else if (sc_q[3]) begin
            if (ir_opcode == OPC_IO) begin
                phase_w = PH_EXECUTE;
            end else if (ir_i) begin
                phase_w = PH_INDIRECT;
            end else begin
                phase_w = PH_EXECUTE;
            end
        end
    end

    assign t_state = sc_q;
    assign phase   = phase_w;
    assign r_flag  = r_q;
    assign ien     = ien_q;
    assign int_ack = int_ack_q;
    assign halted  = halted_q;
    assign seq_err = seq_err_q;

endmodule
